int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that sequences the CPU's entry into and exit from interrupt service routines. It collects up to NSRC external interrupt lines, latches rising edges as pending, applies a software-writable mask and fixed-priority selection, and drives a single request/vector handshake into the CPU's fetch logic. It sits beside the CPU core on the same clock and reset, between the interrupt sources and the CPU's PC-load path.

## Interface
- NSRC, 4: number of interrupt sources, 1–8.
- VEC_W, 10: width of the vector address, equal to the program-counter width.
- VEC_BASE, 10'h3C0: vector address of source 0. Source i vectors to VEC_BASE + 4*i.
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  NSRC  raw interrupt lines, synchronous to clk, rising-edge triggered.
- mask_we  in  1  load mask_din into the mask register.
- mask_din  in  NSRC  new mask value. 1 = source masked.
- cpu_iack  in  1  CPU has taken the vector. Honoured only in state REQ.
- cpu_reti  in  1  CPU executed return-from-interrupt. Honoured only in state SERVICE.
- int_req  out  1  interrupt request to the CPU. Registered; high exactly in state REQ.
- int_vec  out  VEC_W  vector address. Valid and stable while int_req is high.
- int_id  out  3  index of the selected source. Valid in REQ and SERVICE.
- pending  out  NSRC  pending register, readable by the CPU.
- in_service  out  1  high in state SERVICE.

## Operation
- Edge detect: irq_q <= irq_in each cycle. A bit is a new edge when irq_in & ~irq_q is set for that bit.
- Pending: each new edge sets its bit in pending. The bit clears only when that source is acknowledged.
  - If an edge arrives on the same cycle as the acknowledge for the same bit, the bit stays set. The new edge is not lost.
- Eligible set: pending & ~mask. The selected source is the lowest-index eligible bit (source 0 has highest priority).
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when the eligible set is non-zero. int_id and int_vec are latched from the selected source on this transition.
  - REQ -> SERVICE on cpu_iack. The pending bit for int_id clears.
  - SERVICE -> IDLE on cpu_reti.
- No nesting. Higher-priority edges arriving during REQ or SERVICE only set pending.
- Latching is final: a mask write or a higher-priority edge during REQ does not change int_id or int_vec, and does not withdraw int_req.
- cpu_iack outside REQ and cpu_reti outside SERVICE are ignored and have no side effects.
- Mask: mask_we loads mask_din at the clock edge and takes effect in the eligibility check on the next cycle.
- Vector arithmetic: VEC_BASE + {int_id, 2'b00}, computed modulo 2^VEC_W. Wrap-around past the top of memory is permitted and not flagged.

## Timing
- Reset values, applied immediately and asynchronously:
  - state = IDLE
  - irq_q = 0, pending = 0, mask = all ones
  - int_req = 0, int_vec = 0, int_id = 0, in_service = 0
- Edge latency: an irq_in rise sampled at edge n shows in pending after edge n+1.
- Request latency: with the source unmasked, int_req rises after edge n+2.
- Acknowledge latency: cpu_iack sampled at edge k drops int_req, raises in_service, and clears the pending bit after edge k.
- Return latency: cpu_reti sampled at edge r returns the FSM to IDLE after edge r. If another source is still eligible, int_req rises again after edge r+1.
  - This gives a minimum of one IDLE cycle between back-to-back services.
- Reset asserted mid-operation, including during REQ with cpu_iack high, discards everything: all pending requests are lost and no acknowledge is recorded.

## Structure
- Package int_pkg holds:
  - the state enum {IDLE, REQ, SERVICE}
  - default constants for NSRC, VEC_W and VEC_BASE
  - the ID_W = 3 constant
- Sub-module int_prio_enc: a purely combinational lowest-index-first priority encoder. It takes NSRC bits and outputs {valid, id}.
- The edge detector, pending register, mask register and FSM stay in int_ctrl.

## Test plan
- Reset, then write mask = 4'b0000 and pulse irq_in[2] once.
  - Expect: pending = 4'b0100 two cycles later, then int_req = 1, int_id = 2, int_vec = 10'h3C8.
  - cpu_iack -> pending = 0 and in_service = 1. cpu_reti -> IDLE.
- Raise irq_in[1] and irq_in[3] on the same cycle.
  - Expect: source 1 is served first (int_vec = 10'h3C4).
  - After reti, one IDLE cycle, then source 3 is served (int_vec = 10'h3CC).
- Leave the mask at its reset value and pulse irq_in[0].
  - Expect: pending[0] = 1 with int_req held at 0.
  - Write mask = 0 -> int_req rises two cycles after mask_we.
- During REQ for source 2, pulse irq_in[0] and write mask = 4'b1111.
  - Expect: int_id stays at 2 and int_req stays high until cpu_iack.
  - pending[0] = 1 is retained after the acknowledge.
- Rising edge on irq_in[2] in the same cycle as cpu_iack for source 2 -> pending[2] is still 1 after the acknowledge.
- Assert reset while in SERVICE with pending = 4'b1010.
  - Expect: all outputs return to reset values asynchronously, and no int_req appears after reset is released.

Source files
------------

// File: rtl/int_pkg.sv
// Shared types and default constants for the interrupt controller.
package int_pkg;

  localparam int unsigned NSRC_DEFAULT     = 4;
  localparam int unsigned VEC_W_DEFAULT    = 10;
  localparam logic [9:0]  VEC_BASE_DEFAULT = 10'h3C0;
  localparam int unsigned ID_W             = 3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder; bit 0 has the highest priority.
module int_prio_enc
  import int_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge capture, pending/mask registers and the
// single-level request/acknowledge/return handshake towards the CPU.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned      NSRC     = NSRC_DEFAULT,
  parameter int unsigned      VEC_W    = VEC_W_DEFAULT,
  parameter logic [VEC_W-1:0] VEC_BASE = VEC_W'(VEC_BASE_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NSRC-1:0]  irq_in,
  input  logic             mask_we,
  input  logic [NSRC-1:0]  mask_din,
  input  logic             cpu_iack,
  input  logic             cpu_reti,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [ID_W-1:0]  int_id,
  output logic [NSRC-1:0]  pending,
  output logic             in_service
);

  state_e state_q, state_d;

  logic [NSRC-1:0]  irq_q;
  logic [NSRC-1:0]  edge_q;
  logic [NSRC-1:0]  pending_q, pending_d;
  logic [NSRC-1:0]  mask_q;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  ack_clr;
  logic             sel_valid;
  logic [ID_W-1:0]  sel_id;
  logic [ID_W-1:0]  id_q;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             int_req_q;
  logic             in_service_q;
  logic             latch_sel;
  logic             ack;

  assign eligible = pending_q & ~mask_q;

  int_prio_enc #(
    .N (NSRC)
  ) u_prio_enc (
    .req   (eligible),
    .valid (sel_valid),
    .id    (sel_id)
  );

  assign vec_d = VEC_BASE + VEC_W'({sel_id, 2'b00});

  always_comb begin
    state_d   = state_q;
    latch_sel = 1'b0;
    ack       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_valid) begin
          state_d   = StReq;
          latch_sel = 1'b1;
        end
      end
      StReq: begin
        if (cpu_iack) begin
          state_d = StService;
          ack     = 1'b1;
        end
      end
      StService: begin
        if (cpu_reti) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A fresh edge wins over the acknowledge clear so it is never lost.
  always_comb begin
    ack_clr   = ack ? (NSRC'(1) << id_q) : '0;
    pending_d = (pending_q & ~ack_clr) | edge_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      irq_q        <= '0;
      edge_q       <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      id_q         <= '0;
      vec_q        <= '0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_in;
      edge_q       <= irq_in & ~irq_q;
      pending_q    <= pending_d;
      int_req_q    <= (state_d == StReq);
      in_service_q <= (state_d == StService);
      if (mask_we) begin
        mask_q <= mask_din;
      end
      if (latch_sel) begin
        id_q  <= sel_id;
        vec_q <= vec_d;
      end
    end
  end

  assign int_req    = int_req_q;
  assign in_service = in_service_q;
  assign int_id     = id_q;
  assign int_vec    = vec_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;
  import int_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_din;
  logic       cpu_iack;
  logic       cpu_reti;
  logic       int_req;
  logic [9:0] int_vec;
  logic [2:0] int_id;
  logic [3:0] pending;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_din   (mask_din),
    .cpu_iack   (cpu_iack),
    .cpu_reti   (cpu_reti),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_id     (int_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    irq_in   = '0;
    mask_we  = 1'b0;
    mask_din = '0;
    cpu_iack = 1'b0;
    cpu_reti = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we  = 1'b1;
    mask_din = m;
    tick();
    mask_we  = 1'b0;
  endtask

  task automatic pulse_irq(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask

  initial begin
    do_reset();
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_int_vec", 32'(int_vec), 32'd0);
    check("rst_int_id", 32'(int_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_in_service", 32'(in_service), 32'd0);

    // Single source 2.
    write_mask(4'b0000);
    pulse_irq(4'b0100);
    check("t1_pend_early", 32'(pending), 32'h0);
    tick();
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_req_early", 32'(int_req), 32'd0);
    tick();
    check("t1_int_req", 32'(int_req), 32'd1);
    check("t1_int_id", 32'(int_id), 32'd2);
    check("t1_int_vec", 32'(int_vec), 32'h3C8);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    check("t1_ack_req", 32'(int_req), 32'd0);
    check("t1_ack_svc", 32'(in_service), 32'd1);
    check("t1_ack_pend", 32'(pending), 32'h0);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    check("t1_reti_svc", 32'(in_service), 32'd0);
    check("t1_reti_req", 32'(int_req), 32'd0);

    // Sources 1 and 3 together: 1 first, one idle cycle, then 3.
    pulse_irq(4'b1010);
    tick();
    tick();
    check("t2_req1", 32'(int_req), 32'd1);
    check("t2_id1", 32'(int_id), 32'd1);
    check("t2_vec1", 32'(int_vec), 32'h3C4);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    check("t2_pend_after_ack", 32'(pending), 32'h8);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    check("t2_idle_gap", 32'(int_req), 32'd0);
    tick();
    check("t2_req3", 32'(int_req), 32'd1);
    check("t2_id3", 32'(int_id), 32'd3);
    check("t2_vec3", 32'(int_vec), 32'h3CC);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    check("t2_pend_empty", 32'(pending), 32'h0);

    // Reset mask holds source 0 back until unmasked.
    do_reset();
    pulse_irq(4'b0001);
    tick();
    tick();
    check("t3_pending", 32'(pending), 32'h1);
    check("t3_masked_req", 32'(int_req), 32'd0);
    write_mask(4'b0000);
    check("t3_req_mask_edge", 32'(int_req), 32'd0);
    tick();
    check("t3_req_after", 32'(int_req), 32'd1);
    check("t3_vec0", 32'(int_vec), 32'h3C0);

    // Latched request is final despite a new edge and a mask write.
    do_reset();
    write_mask(4'b0000);
    pulse_irq(4'b0100);
    tick();
    tick();
    check("t4_req", 32'(int_req), 32'd1);
    irq_in   = 4'b0001;
    mask_we  = 1'b1;
    mask_din = 4'b1111;
    tick();
    irq_in  = '0;
    mask_we = 1'b0;
    tick();
    tick();
    check("t4_req_held", 32'(int_req), 32'd1);
    check("t4_id_held", 32'(int_id), 32'd2);
    check("t4_vec_held", 32'(int_vec), 32'h3C8);
    check("t4_pending", 32'(pending), 32'h5);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    check("t4_pend_kept", 32'(pending), 32'h1);
    check("t4_svc", 32'(in_service), 32'd1);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    tick();
    check("t4_masked_idle", 32'(int_req), 32'd0);
    // Stray handshakes in IDLE must not disturb anything.
    cpu_iack = 1'b1;
    cpu_reti = 1'b1;
    tick();
    cpu_iack = 1'b0;
    cpu_reti = 1'b0;
    check("t4_stray_pend", 32'(pending), 32'h1);
    check("t4_stray_svc", 32'(in_service), 32'd0);

    // New edge on source 2 lands in pending on the acknowledge edge.
    do_reset();
    write_mask(4'b0000);
    pulse_irq(4'b0100);
    tick();
    tick();
    check("t5_req", 32'(int_req), 32'd1);
    pulse_irq(4'b0100);
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    check("t5_pend_kept", 32'(pending), 32'h4);
    check("t5_svc", 32'(in_service), 32'd1);
    cpu_reti = 1'b1;
    tick();
    cpu_reti = 1'b0;
    tick();
    check("t5_rereq", 32'(int_req), 32'd1);
    check("t5_reid", 32'(int_id), 32'd2);

    // Asynchronous reset in SERVICE with 1 and 3 pending.
    do_reset();
    write_mask(4'b0000);
    pulse_irq(4'b0100);
    tick();
    tick();
    cpu_iack = 1'b1;
    tick();
    cpu_iack = 1'b0;
    pulse_irq(4'b1010);
    tick();
    check("t6_svc", 32'(in_service), 32'd1);
    check("t6_pending", 32'(pending), 32'hA);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_pend", 32'(pending), 32'h0);
    check("t6_async_svc", 32'(in_service), 32'd0);
    check("t6_async_id", 32'(int_id), 32'd0);
    check("t6_async_vec", 32'(int_vec), 32'd0);
    check("t6_async_req", 32'(int_req), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("t6_post_req", 32'(int_req), 32'd0);
    check("t6_post_pend", 32'(pending), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
